mem_reader: RTL and testbench
=============================

MEM_READER -- requirements
Module: mem_reader

Interface
REQ-001 Parameter SIZE, default 14, RAM address width in bits.
REQ-002 Parameter DEPTH, default 1024, number of addressable words; addresses beyond DEPTH-1 are never issued.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle command pulse, sampled only in IDLE.
REQ-006 start_addr  input  SIZE  first word address of the transfer.
REQ-007 count  input  SIZE+1  number of words to read, 0..DEPTH.
REQ-008 busy  output  1  high from the cycle after an accepted start until done.
REQ-009 done  output  1  one-cycle pulse when the last word has left the output port.
REQ-010 wrEn  output  1  RAM write enable, held 0 at all times (read-only initiator).
REQ-011 addr_toRAM  output  SIZE  RAM read address.
REQ-012 data_toRAM  output  32  RAM write data, held 0 at all times.
REQ-013 data_fromRAM  input  32  RAM read data, valid one cycle after addr_toRAM is presented.
REQ-014 o_valid  output  1  output word valid.
REQ-015 o_data  output  32  output word.
REQ-016 o_addr  output  SIZE  RAM address that o_data was read from.
REQ-017 i_ready  input  1  downstream accepts the word when o_valid and i_ready are both high.

Function
REQ-018 States: IDLE, RUN, DRAIN; IDLE -> RUN on start with count>0; IDLE -> DRAIN on start with count=0; RUN -> DRAIN when the last read is issued; DRAIN -> IDLE when no words are in flight or buffered, with done pulsed in that cycle.
REQ-019 Start with count=0 produces no reads, busy high for one cycle, done on the second cycle after start.
REQ-020 Reads are issued in ascending address order beginning at start_addr, one per cycle at most.
REQ-021 The address increments modulo 2**SIZE, wrapping from 2**SIZE-1 to 0.
REQ-022 A read is issued only when (buffered words + reads in flight) < 2, so no returned word is ever dropped.
REQ-023 Returned data is captured on the cycle after the read together with its address tag, into a 2-entry FIFO that drives o_valid, o_data and o_addr.
REQ-024 With i_ready held high, throughput is one word per cycle; the first o_valid occurs 2 cycles after start.
REQ-025 o_data, o_addr and o_valid hold stable while o_valid=1 and i_ready=0.
REQ-026 start while busy is ignored, with no effect on the transfer in progress.
REQ-027 When idle, addr_toRAM holds its last value; it is 0 after reset.

Reset
REQ-028 On rst low: state IDLE; busy, done, o_valid, wrEn and data_toRAM at 0; addr_toRAM, o_data and o_addr at 0; FIFO emptied.
REQ-029 Reset asserted mid-transfer aborts it: in-flight reads are discarded and no done is generated.
REQ-030 The first start is accepted on the first rising edge after rst is released.

Structure
REQ-031 Shared package holds the state enumeration (IDLE, RUN, DRAIN) and the default SIZE/DEPTH constants (14, 1024).
REQ-032 One sub-module, rd_fifo2: a 2-entry FIFO of {SIZE-bit addr, 32-bit data} with push, pop, count, full and empty.

Verification
REQ-033 RAM[100..103]=A,B,C,D; start_addr=100, count=4, i_ready=1 -> o_data A,B,C,D on 4 consecutive cycles, o_addr 100..103, first o_valid 2 cycles after start, done once.
REQ-034 Same stimulus with i_ready toggling 1,0,0,1,... -> identical ordered output, no loss or duplication, outputs stable while stalled, wrEn never 1.
REQ-035 SIZE=4, start_addr=14, count=4 -> o_addr sequence 14,15,0,1.
REQ-036 count=0 -> no o_valid; busy for 1 cycle; done on the 2nd cycle after start.
REQ-037 rst low at the 3rd word of count=8 -> all outputs 0 at once; a fresh start afterwards with count=2 returns exactly 2 correct words.
REQ-038 start pulsed again mid-transfer with a different start_addr -> ignored; the original sequence completes unchanged.

Source files
------------

// File: rtl/mem_reader_pkg.sv
// mem_reader_pkg
// Shared definitions for the mem_reader block: the controller state
// enumeration and the default address width / RAM depth.
package mem_reader_pkg;

   localparam int DEF_SIZE  = 14;     // RAM address width in bits
   localparam int DEF_DEPTH = 1024;   // number of addressable RAM words

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

endpackage

// File: rtl/mem_reader_rd_fifo2.sv
// rd_fifo2
// Two-entry FIFO of {address tag, data word}. The head entry is presented
// combinationally from the storage registers, so it holds steady until popped.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset, empties the FIFO and zeroes storage
//   push       write push_addr/push_data (accepted when not full, or full and popping)
//   push_addr  address tag of the pushed word
//   push_data  data of the pushed word
//   pop        remove the head entry (ignored when empty)
//   head_addr  address tag of the head entry
//   head_data  data of the head entry
//   count      number of stored entries, 0..2
//   full       count == 2
//   empty      count == 0
module rd_fifo2
   import mem_reader_pkg::*;
#(
   parameter int SIZE = DEF_SIZE
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic [SIZE-1:0] push_addr,
   input  logic [31:0]     push_data,
   input  logic            pop,
   output logic [SIZE-1:0] head_addr,
   output logic [31:0]     head_data,
   output logic [1:0]      count,
   output logic            full,
   output logic            empty
);

   logic [SIZE-1:0] addr_mem [2];
   logic [31:0]     data_mem [2];
   logic            wr_ptr_reg;
   logic            rd_ptr_reg;
   logic [1:0]      count_reg;
   logic            do_push;
   logic            do_pop;

   assign do_pop  = pop && (count_reg != 2'd0);
   // A full FIFO may take a push in the same cycle its head leaves: the
   // write lands in the slot being vacated.
   assign do_push = push && ((count_reg != 2'd2) || do_pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            addr_mem[i] <= '0;
            data_mem[i] <= '0;
         end
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (do_push) begin
            addr_mem[wr_ptr_reg] <= push_addr;
            data_mem[wr_ptr_reg] <= push_data;
            wr_ptr_reg           <= ~wr_ptr_reg;
         end
         if (do_pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head_addr = addr_mem[rd_ptr_reg];
   assign head_data = data_mem[rd_ptr_reg];
   assign count     = count_reg;
   assign full      = (count_reg == 2'd2);
   assign empty     = (count_reg == 2'd0);

endmodule

// File: rtl/mem_reader.sv
// mem_reader
// Read-only RAM initiator. On an accepted start it reads `count` consecutive
// words beginning at start_addr (address wrapping modulo 2**SIZE) from a RAM
// with one-cycle read latency and streams them, tagged with their address,
// through a valid/ready output port. At most two words are ever buffered or
// in flight, so backpressure never drops a word.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-low reset
//   start         command pulse, honoured only while idle
//   start_addr    first word address
//   count         number of words, 0..DEPTH
//   busy          transfer in progress
//   done          one-cycle pulse once the last word has been taken
//   wrEn          RAM write enable (always 0)
//   addr_toRAM    RAM read address
//   data_toRAM    RAM write data (always 0)
//   data_fromRAM  RAM read data, valid the cycle after the address
//   o_valid       output word valid
//   o_data        output word
//   o_addr        RAM address the output word came from
//   i_ready       downstream ready
module mem_reader
   import mem_reader_pkg::*;
#(
   parameter int SIZE  = DEF_SIZE,
   parameter int DEPTH = DEF_DEPTH
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [SIZE-1:0] start_addr,
   input  logic [SIZE:0]   count,
   output logic            busy,
   output logic            done,
   output logic            wrEn,
   output logic [SIZE-1:0] addr_toRAM,
   output logic [31:0]     data_toRAM,
   input  logic [31:0]     data_fromRAM,
   output logic            o_valid,
   output logic [31:0]     o_data,
   output logic [SIZE-1:0] o_addr,
   input  logic            i_ready
);

   localparam logic [SIZE:0] MAX_COUNT = (SIZE+1)'(DEPTH);
   localparam logic [SIZE:0] CNT_ONE   = (SIZE+1)'(1);

   rd_state_t       state_reg,        state_next;
   logic [SIZE:0]   remaining_reg,    remaining_next;
   logic [SIZE-1:0] next_addr_reg,    next_addr_next;
   logic [SIZE-1:0] addr_hold_reg;
   logic            inflight_reg;
   logic [SIZE-1:0] inflight_addr_reg;
   logic            done_reg,         done_next;

   logic            issue;
   logic [SIZE-1:0] issue_addr;
   logic [SIZE:0]   req_count;
   logic            pop;
   logic            room;
   logic            drained;
   logic [2:0]      occupancy;

   logic [1:0]      fifo_count;
   logic            fifo_full;
   logic            fifo_empty;

   // Requests larger than the RAM are clamped rather than reading past it.
   assign req_count = (count > MAX_COUNT) ? MAX_COUNT : count;

   assign pop = !fifo_empty && i_ready;

   // Words that will still occupy the pipe after this cycle: buffered words
   // that are not leaving now plus the read whose data arrives next edge.
   assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, pop};
   // The full-and-stalled term is redundant with the occupancy test; it keeps
   // the FIFO from ever being offered a word it cannot hold.
   assign room      = (occupancy < 3'd2) && !(fifo_full && !pop);
   assign drained   = (fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop);

   always_comb begin
      state_next     = state_reg;
      remaining_next = remaining_reg;
      next_addr_next = next_addr_reg;
      done_next      = 1'b0;
      issue          = 1'b0;
      issue_addr     = next_addr_reg;

      unique case (state_reg)
         IDLE: begin
            // The first read goes out in the start cycle itself so that data
            // reaches the output two cycles later. rst is included so that a
            // start held during reset cannot move the RAM address.
            if (start && rst) begin
               if (req_count == '0) begin
                  state_next = DRAIN;
               end else begin
                  issue          = 1'b1;
                  issue_addr     = start_addr;
                  next_addr_next = start_addr + 1'b1;
                  remaining_next = req_count - CNT_ONE;
                  state_next     = RUN;
               end
            end
         end
         RUN: begin
            if (remaining_reg == '0) begin
               state_next = DRAIN;
            end else if (room) begin
               issue          = 1'b1;
               issue_addr     = next_addr_reg;
               next_addr_next = next_addr_reg + 1'b1;
               remaining_next = remaining_reg - CNT_ONE;
               if (remaining_reg == CNT_ONE) begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (!inflight_reg && drained) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg         <= IDLE;
         remaining_reg     <= '0;
         next_addr_reg     <= '0;
         addr_hold_reg     <= '0;
         inflight_reg      <= 1'b0;
         inflight_addr_reg <= '0;
         done_reg          <= 1'b0;
      end else begin
         state_reg         <= state_next;
         remaining_reg     <= remaining_next;
         next_addr_reg     <= next_addr_next;
         inflight_reg      <= issue;
         inflight_addr_reg <= issue_addr;
         done_reg          <= done_next;
         if (issue) begin
            addr_hold_reg <= issue_addr;
         end
      end
   end

   // The address of the read going out this cycle, otherwise the last one.
   assign addr_toRAM = issue ? issue_addr : addr_hold_reg;

   rd_fifo2 #(
      .SIZE (SIZE)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_reg),
      .push_addr (inflight_addr_reg),
      .push_data (data_fromRAM),
      .pop       (pop),
      .head_addr (o_addr),
      .head_data (o_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign o_valid    = !fifo_empty;
   assign busy       = (state_reg != IDLE);
   assign done       = done_reg;
   assign wrEn       = 1'b0;
   assign data_toRAM = '0;

endmodule

// File: tb/tb_mem_reader.sv
module tb_mem_reader;

   localparam int SIZE   = 14;
   localparam int DEPTH  = 1024;
   localparam int SSIZE  = 4;
   localparam int SDEPTH = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // main instance
   logic            start = 1'b0;
   logic [SIZE-1:0] start_addr = '0;
   logic [SIZE:0]   count = '0;
   logic            busy, done, wrEn;
   logic [SIZE-1:0] addr_toRAM;
   logic [31:0]     data_toRAM;
   logic [31:0]     data_fromRAM = '0;
   logic            o_valid;
   logic [31:0]     o_data;
   logic [SIZE-1:0] o_addr;
   logic            i_ready = 1'b1;

   // small instance for address wrap
   logic             start_s = 1'b0;
   logic [SSIZE-1:0] start_addr_s = '0;
   logic [SSIZE:0]   count_s = '0;
   logic             busy_s, done_s, wrEn_s;
   logic [SSIZE-1:0] addr_toRAM_s;
   logic [31:0]      data_toRAM_s;
   logic [31:0]      data_fromRAM_s = '0;
   logic             o_valid_s;
   logic [31:0]      o_data_s;
   logic [SSIZE-1:0] o_addr_s;
   logic             i_ready_s = 1'b1;

   mem_reader #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .count(count),
      .busy(busy), .done(done), .wrEn(wrEn), .addr_toRAM(addr_toRAM),
      .data_toRAM(data_toRAM), .data_fromRAM(data_fromRAM),
      .o_valid(o_valid), .o_data(o_data), .o_addr(o_addr), .i_ready(i_ready)
   );

   mem_reader #(.SIZE(SSIZE), .DEPTH(SDEPTH)) dut_s (
      .clk(clk), .rst(rst), .start(start_s), .start_addr(start_addr_s), .count(count_s),
      .busy(busy_s), .done(done_s), .wrEn(wrEn_s), .addr_toRAM(addr_toRAM_s),
      .data_toRAM(data_toRAM_s), .data_fromRAM(data_fromRAM_s),
      .o_valid(o_valid_s), .o_data(o_data_s), .o_addr(o_addr_s), .i_ready(i_ready_s)
   );

   // RAM models: registered read, one cycle latency
   logic [31:0] mem   [DEPTH];
   logic [31:0] mem_s [SDEPTH];
   always @(posedge clk) data_fromRAM   <= mem[int'(addr_toRAM) % DEPTH];
   always @(posedge clk) data_fromRAM_s <= mem_s[addr_toRAM_s];

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [SIZE-1:0] a;
      logic [31:0]     d;
   } exp_t;

   typedef struct {
      int sa;
      int cnt;
      int mode;       // 0: ready high, 1: ready 1,0,0,..., 2: random ready
      int restart;    // cycle (after start) at which start is pulsed again, -1 none
      int exp_first;  // cycle of first o_valid, -1 none, -2 unchecked
      int exp_done;   // cycle of done, -1 unchecked
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic ready_for(input int mode, input int lat);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (lat % 3) == 0;
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic run_xfer(input int sa, input int cnt, input int mode, input int restart_lat,
                           input int exp_first, input int exp_done);
      exp_t q[$];
      exp_t e;
      int lat = 0;
      int first_lat = -1, done_lat = -1, last_lat = -1;
      int done_cnt = 0, busy_cnt = 0, words = 0;
      bit prev_stall = 1'b0;
      bit wr_bad = 1'b0;
      logic [31:0] prev_d = '0;
      logic [SIZE-1:0] prev_a = '0;
      // reference: word i comes from address (sa+i) mod 2**SIZE
      for (int i = 0; i < cnt; i++) begin
         e.a = SIZE'((sa + i) % (1 << SIZE));
         e.d = mem[int'(e.a)];
         q.push_back(e);
      end
      @(negedge clk);
      start = 1'b1;
      start_addr = SIZE'(sa);
      count = (SIZE+1)'(cnt);
      i_ready = ready_for(mode, 0);
      while (lat < 400 && (done_lat < 0 || lat < done_lat + 2)) begin
         @(negedge clk);
         lat++;
         start = (lat == restart_lat);
         if (lat == restart_lat) start_addr = SIZE'(sa + 37);
         if (wrEn !== 1'b0 || data_toRAM !== 32'd0) wr_bad = 1'b1;
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_lat < 0) done_lat = lat;
         end
         if (prev_stall)
            check("stall_hold", {o_valid, o_addr, o_data}, {1'b1, prev_a, prev_d});
         if (o_valid && first_lat < 0) first_lat = lat;
         i_ready = ready_for(mode, lat);
         if (o_valid && i_ready) begin
            if (q.size() == 0) begin
               check("extra_word", words + 1, cnt);
            end else begin
               e = q.pop_front();
               check("o_addr", o_addr, e.a);
               check("o_data", o_data, e.d);
            end
            words++;
            last_lat = lat;
         end
         prev_stall = o_valid && !i_ready;
         prev_a = o_addr;
         prev_d = o_data;
      end
      start = 1'b0;
      i_ready = 1'b1;
      check("words", words, cnt);
      check("done_count", done_cnt, 1);
      check("wr_zero", wr_bad, 0);
      if (exp_first != -2) check("first_valid_lat", first_lat, exp_first);
      if (exp_done > 0) begin
         check("done_lat", done_lat, exp_done);
         check("busy_cycles", busy_cnt, exp_done - 1);
         if (cnt > 0) check("last_word_lat", last_lat, cnt + 1);
      end
      $display("[TB] xfer sa=%0d cnt=%0d mode=%0d restart=%0d words=%0d first=%0d done_lat=%0d",
               sa, cnt, mode, restart_lat, words, first_lat, done_lat);
   endtask

   task automatic reset_mid();
      int words = 0;
      int done_seen = 0;
      int lat = 0;
      @(negedge clk);
      start = 1'b1; start_addr = SIZE'(200); count = (SIZE+1)'(8); i_ready = 1'b1;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         start = 1'b0;
         if (words == 2 && o_valid) break;
         if (o_valid) begin
            check("pre_rst_addr", o_addr, 200 + words);
            check("pre_rst_data", o_data, mem[200 + words]);
            words++;
         end
      end
      check("third_word_reached", words, 2);
      rst = 1'b0;
      #1;
      check("abort_o_valid", o_valid, 0);
      check("abort_o_data", o_data, 0);
      check("abort_o_addr", o_addr, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_addr_toRAM", addr_toRAM, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (done || o_valid) done_seen++;
      end
      check("no_output_after_abort", done_seen, 0);
      $display("[TB] reset mid-transfer after %0d words", words);
      run_xfer(300, 2, 0, -1, 2, 4);
   endtask

   task automatic wrap_test();
      logic [SSIZE-1:0] exp_a;
      int n = 0;
      @(negedge clk);
      start_s = 1'b1; start_addr_s = SSIZE'(14); count_s = (SSIZE+1)'(4);
      for (int lat = 1; lat <= 12; lat++) begin
         @(negedge clk);
         start_s = 1'b0;
         if (o_valid_s) begin
            exp_a = SSIZE'((14 + n) % 16);
            check("wrap_addr", o_addr_s, exp_a);
            check("wrap_data", o_data_s, mem_s[exp_a]);
            n++;
         end
      end
      check("wrap_words", n, 4);
      $display("[TB] wrap SIZE=4 start=14 cnt=4 words=%0d", n);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      mem[100] = 32'hAAAA_0100;
      mem[101] = 32'hBBBB_0101;
      mem[102] = 32'hCCCC_0102;
      mem[103] = 32'hDDDD_0103;
      for (int i = 0; i < SDEPTH; i++) mem_s[i] = 32'h5000_0000 + i;

      vecs[0] = '{100, 4, 0, -1, 2, 6};
      vecs[1] = '{100, 4, 1, -1, 2, -1};
      vecs[2] = '{500, 0, 0, -1, -1, 2};
      vecs[3] = '{10, 1, 0, -1, 2, 3};
      vecs[4] = '{700, 16, 0, -1, 2, 18};
      vecs[5] = '{100, 4, 0, 2, 2, 6};
      vecs[6] = '{1019, 5, 2, 3, 2, -1};
      vecs[7] = '{0, 8, 1, -1, 2, -1};

      // reset state
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_o_valid", o_valid, 0);
      check("rst_o_data", o_data, 0);
      check("rst_o_addr", o_addr, 0);
      check("rst_addr_toRAM", addr_toRAM, 0);
      check("rst_wrEn", wrEn, 0);
      check("rst_data_toRAM", data_toRAM, 0);
      // release just after a rising edge; the first transfer's start is then
      // seen on the very next rising edge
      @(posedge clk);
      #2 rst = 1'b1;

      foreach (vecs[k])
         run_xfer(vecs[k].sa, vecs[k].cnt, vecs[k].mode, vecs[k].restart,
                  vecs[k].exp_first, vecs[k].exp_done);

      wrap_test();
      reset_mid();

      for (int r = 0; r < 30; r++) begin
         int cnt, sa, rl;
         cnt = $urandom_range(0, 12);
         sa  = $urandom_range(0, DEPTH - cnt);
         rl  = (cnt > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, 2) : -1;
         run_xfer(sa, cnt, 2, rl, (cnt > 0) ? 2 : -1, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule
